// File: rtl/route_compute_wh.sv
// Route-compute stage for one mesh-router input port: XY/YX routing,
// wormhole port locking and a one-entry valid/ready output register.
// Ports: clk, rst (async, active-high); flit_in/flit_in_valid/flit_in_ready
// upstream; flit_out/flit_out_valid/flit_out_ready, port_num, port_en
// downstream; err (one-cycle pulse) and err_cnt (saturating count).
module route_compute_wh #(
  parameter int X_NODE_NUM       = 4,
  parameter int Y_NODE_NUM       = 4,
  parameter int X_NODE_NUM_WIDTH = 2,
  parameter int Y_NODE_NUM_WIDTH = 2,
  parameter int X_S_ADDRESS      = 1,
  parameter int Y_S_ADDRESS      = 0,
  parameter int FLIT_W           = 8,
  parameter int ROUTING          = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [FLIT_W-1:0] flit_in,
  input  logic              flit_in_valid,
  output logic              flit_in_ready,
  output logic [FLIT_W-1:0] flit_out,
  output logic              flit_out_valid,
  input  logic              flit_out_ready,
  output logic [3:0]        port_num,
  output logic [4:0]        port_en,
  output logic              err,
  output logic [7:0]        err_cnt
);

  localparam int XW = X_NODE_NUM_WIDTH;
  localparam int YW = Y_NODE_NUM_WIDTH;

  localparam logic [31:0] XC = 32'(X_S_ADDRESS);
  localparam logic [31:0] YC = 32'(Y_S_ADDRESS);
  localparam logic [31:0] XN = 32'(X_NODE_NUM);
  localparam logic [31:0] YN = 32'(Y_NODE_NUM);

  localparam logic [3:0] P_L = 4'd1;
  localparam logic [3:0] P_E = 4'd2;
  localparam logic [3:0] P_N = 4'd3;
  localparam logic [3:0] P_W = 4'd4;
  localparam logic [3:0] P_S = 4'd5;

  typedef enum logic [1:0] {
    IDLE,
    LOCKED,
    DROP
  } state_t;

  state_t      state;
  state_t      nxt;
  logic [3:0]  lock_port;
  logic [3:0]  lock_nxt;
  logic [3:0]  out_port;
  logic [3:0]  route;
  logic [1:0]  ftype;
  logic [31:0] xd;
  logic [31:0] yd;
  logic        legal;
  logic        acc;
  logic        emit;
  logic        err_hit;

  assign ftype = flit_in[FLIT_W-1 -: 2];
  assign xd    = 32'(flit_in[XW-1:0]);
  assign yd    = 32'(flit_in[XW +: YW]);
  assign legal = (xd < XN) && (yd < YN);

  assign flit_in_ready = !flit_out_valid || flit_out_ready;
  assign acc = flit_in_valid && flit_in_ready;

  // Dimension-order route; y grows southward.
  always_comb begin
    route = P_L;
    if (ROUTING == 0) begin
      if (xd > XC)      route = P_E;
      else if (xd < XC) route = P_W;
      else if (yd > YC) route = P_S;
      else if (yd < YC) route = P_N;
    end else begin
      if (yd > YC)      route = P_S;
      else if (yd < YC) route = P_N;
      else if (xd > XC) route = P_E;
      else if (xd < XC) route = P_W;
    end
  end

  // ftype[1] set: header or single-flit; ftype[0] set: closes packet.
  always_comb begin
    emit     = 1'b0;
    err_hit  = 1'b0;
    nxt      = state;
    out_port = lock_port;
    lock_nxt = lock_port;
    if (ftype[1]) begin
      err_hit = (state != IDLE) || !legal;
      nxt     = IDLE;
      if (legal) begin
        emit     = 1'b1;
        out_port = route;
        if (!ftype[0]) begin
          nxt      = LOCKED;
          lock_nxt = route;
        end
      end else if (!ftype[0]) begin
        nxt = DROP;
      end
    end else begin
      case (state)
        LOCKED: begin
          emit = 1'b1;
          if (ftype[0]) nxt = IDLE;
        end
        DROP: begin
          if (ftype[0]) nxt = IDLE;
        end
        default: err_hit = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      lock_port      <= '0;
      flit_out_valid <= 1'b0;
      flit_out       <= '0;
      port_num       <= '0;
      err            <= 1'b0;
      err_cnt        <= '0;
    end else begin
      err <= acc && err_hit;
      if (acc && err_hit && err_cnt != 8'hFF)
        err_cnt <= err_cnt + 8'd1;
      if (acc) begin
        state     <= nxt;
        lock_port <= lock_nxt;
      end
      if (acc && emit) begin
        flit_out_valid <= 1'b1;
        flit_out       <= flit_in;
        port_num       <= out_port;
      end else if (flit_out_ready) begin
        flit_out_valid <= 1'b0;
      end
    end
  end

  always_comb begin
    port_en = 5'b00000;
    case (port_num)
      P_L: port_en = 5'b00001;
      P_E: port_en = 5'b00010;
      P_W: port_en = 5'b00100;
      P_S: port_en = 5'b01000;
      P_N: port_en = 5'b10000;
      default: port_en = 5'b00000;
    endcase
  end

endmodule

// File: tb/tb_route_compute_wh.sv
// Bench for route_compute_wh: three instances (XY, YX, 3-column mesh)
// on shared inputs, directed scenarios plus a randomized model check.
module tb_route_compute_wh;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] flit_in;
  logic       flit_in_valid;
  logic       flit_out_ready;

  logic       in_rdy [3];
  logic [7:0] fo     [3];
  logic       fov    [3];
  logic [3:0] pn     [3];
  logic [4:0] pe     [3];
  logic       er     [3];
  logic [7:0] ec     [3];

  int n_cmp = 0;
  int n_bad = 0;

  int xn_of [3] = '{4, 4, 3};
  int rt_of [3] = '{0, 1, 0};

  bit         m_pkt  [3];
  bit         m_drop [3];
  int         m_lock [3];
  bit         m_full [3];
  logic [7:0] m_f    [3];
  int         m_p    [3];
  bit         m_err  [3];
  int         m_cnt  [3];

  always #5 clk = ~clk;

  route_compute_wh #(.ROUTING(0)) u0 (
    .clk(clk), .rst(rst),
    .flit_in(flit_in), .flit_in_valid(flit_in_valid),
    .flit_in_ready(in_rdy[0]),
    .flit_out(fo[0]), .flit_out_valid(fov[0]),
    .flit_out_ready(flit_out_ready),
    .port_num(pn[0]), .port_en(pe[0]),
    .err(er[0]), .err_cnt(ec[0])
  );

  route_compute_wh #(.ROUTING(1)) u1 (
    .clk(clk), .rst(rst),
    .flit_in(flit_in), .flit_in_valid(flit_in_valid),
    .flit_in_ready(in_rdy[1]),
    .flit_out(fo[1]), .flit_out_valid(fov[1]),
    .flit_out_ready(flit_out_ready),
    .port_num(pn[1]), .port_en(pe[1]),
    .err(er[1]), .err_cnt(ec[1])
  );

  route_compute_wh #(.X_NODE_NUM(3)) u2 (
    .clk(clk), .rst(rst),
    .flit_in(flit_in), .flit_in_valid(flit_in_valid),
    .flit_in_ready(in_rdy[2]),
    .flit_out(fo[2]), .flit_out_valid(fov[2]),
    .flit_out_ready(flit_out_ready),
    .port_num(pn[2]), .port_en(pe[2]),
    .err(er[2]), .err_cnt(ec[2])
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] f);
    flit_in       = f;
    flit_in_valid = 1'b1;
    tick();
    flit_in_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst            = 1'b1;
    flit_in_valid  = 1'b0;
    flit_out_ready = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  // Port numbers L=1 E=2 N=3 W=4 S=5; router at (1,0).
  function automatic int route_of(input int xd, input int yd,
                                  input int rt);
    int dx;
    int dy;
    dx = xd - 1;
    dy = yd - 0;
    if (rt == 0) begin
      if (dx != 0) return (dx > 0) ? 2 : 4;
      if (dy != 0) return (dy > 0) ? 5 : 3;
    end else begin
      if (dy != 0) return (dy > 0) ? 5 : 3;
      if (dx != 0) return (dx > 0) ? 2 : 4;
    end
    return 1;
  endfunction

  function automatic logic [4:0] en_of(input int p);
    case (p)
      1: return 5'b00001;
      2: return 5'b00010;
      4: return 5'b00100;
      5: return 5'b01000;
      3: return 5'b10000;
      default: return 5'b00000;
    endcase
  endfunction

  task automatic model_push(input int d, input logic [7:0] f,
                            input int p);
    m_full[d] = 1'b1;
    m_f[d]    = f;
    m_p[d]    = p;
  endtask

  task automatic model_flit(input int d, input logic [7:0] f);
    int xd;
    int yd;
    int r;
    xd = int'(f[1:0]);
    yd = int'(f[3:2]);
    if (f[7]) begin
      if (m_pkt[d] || m_drop[d]) m_err[d] = 1'b1;
      m_pkt[d]  = 1'b0;
      m_drop[d] = 1'b0;
      if (xd >= xn_of[d] || yd >= 4) begin
        m_err[d] = 1'b1;
        if (!f[6]) m_drop[d] = 1'b1;
      end else begin
        r = route_of(xd, yd, rt_of[d]);
        model_push(d, f, r);
        if (!f[6]) begin
          m_pkt[d]  = 1'b1;
          m_lock[d] = r;
        end
      end
    end else if (m_pkt[d]) begin
      model_push(d, f, m_lock[d]);
      if (f[6]) m_pkt[d] = 1'b0;
    end else if (m_drop[d]) begin
      if (f[6]) m_drop[d] = 1'b0;
    end else begin
      m_err[d] = 1'b1;
    end
    if (m_err[d] && m_cnt[d] < 255) m_cnt[d]++;
  endtask

  task automatic test_reset();
    #1;
    n_cmp++;
    if (fov[0] !== 1'b0 || fo[0] !== 8'h00) begin
      n_bad++;
      $display("FAIL rst_out: got v=%0b f=%h want 0/00", fov[0], fo[0]);
    end
    n_cmp++;
    if (pn[0] !== 4'd0 || pe[0] !== 5'd0) begin
      n_bad++;
      $display("FAIL rst_port: got %0d/%b want 0/0", pn[0], pe[0]);
    end
    n_cmp++;
    if (er[0] !== 1'b0 || ec[0] !== 8'd0) begin
      n_bad++;
      $display("FAIL rst_err: got %0b/%0d want 0/0", er[0], ec[0]);
    end
  endtask

  task automatic test_wormhole();
    do_reset();
    send(8'h83);
    n_cmp++;
    if (fov[0] !== 1'b1 || fo[0] !== 8'h83) begin
      n_bad++;
      $display("FAIL wh_hdr: got v=%0b f=%h want 1/83", fov[0], fo[0]);
    end
    n_cmp++;
    if (pn[0] !== 4'd2 || pe[0] !== 5'b00010) begin
      n_bad++;
      $display("FAIL wh_hdr_port: got %0d/%b want 2/00010",
               pn[0], pe[0]);
    end
    send(8'h00);
    n_cmp++;
    if (fov[0] !== 1'b1 || fo[0] !== 8'h00 || pn[0] !== 4'd2) begin
      n_bad++;
      $display("FAIL wh_body: got v=%0b f=%h p=%0d want 1/00/2",
               fov[0], fo[0], pn[0]);
    end
    send(8'h40);
    n_cmp++;
    if (fov[0] !== 1'b1 || fo[0] !== 8'h40 || pn[0] !== 4'd2) begin
      n_bad++;
      $display("FAIL wh_tail: got v=%0b f=%h p=%0d want 1/40/2",
               fov[0], fo[0], pn[0]);
    end
    send(8'h00);
    n_cmp++;
    if (fov[0] !== 1'b0 || er[0] !== 1'b1) begin
      n_bad++;
      $display("FAIL wh_idle: got v=%0b err=%0b want 0/1",
               fov[0], er[0]);
    end
  endtask

  task automatic test_routing();
    do_reset();
    send(8'h88);
    n_cmp++;
    if (pn[0] !== 4'd4 || pe[0] !== 5'b00100) begin
      n_bad++;
      $display("FAIL xy_route: got %0d/%b want 4/00100", pn[0], pe[0]);
    end
    n_cmp++;
    if (pn[1] !== 4'd5 || pe[1] !== 5'b01000) begin
      n_bad++;
      $display("FAIL yx_route: got %0d/%b want 5/01000", pn[1], pe[1]);
    end
  endtask

  task automatic test_local();
    do_reset();
    send(8'h81);
    n_cmp++;
    if (pn[0] !== 4'd1 || pe[0] !== 5'b00001) begin
      n_bad++;
      $display("FAIL loc_hdr: got %0d/%b want 1/00001", pn[0], pe[0]);
    end
    send(8'h00);
    n_cmp++;
    if (fov[0] !== 1'b1 || pn[0] !== 4'd1 || er[0] !== 1'b0) begin
      n_bad++;
      $display("FAIL loc_locked: got v=%0b p=%0d e=%0b want 1/1/0",
               fov[0], pn[0], er[0]);
    end
    send(8'h40);
    send(8'hC1);
    n_cmp++;
    if (fov[0] !== 1'b1 || fo[0] !== 8'hC1 || pn[0] !== 4'd1) begin
      n_bad++;
      $display("FAIL loc_single: got v=%0b f=%h p=%0d want 1/C1/1",
               fov[0], fo[0], pn[0]);
    end
    send(8'h00);
    n_cmp++;
    if (fov[0] !== 1'b0 || er[0] !== 1'b1) begin
      n_bad++;
      $display("FAIL loc_idle: got v=%0b e=%0b want 0/1", fov[0], er[0]);
    end
  endtask

  task automatic test_errors();
    do_reset();
    send(8'h05);
    n_cmp++;
    if (fov[0] !== 1'b0 || er[0] !== 1'b1) begin
      n_bad++;
      $display("FAIL orphan: got v=%0b e=%0b want 0/1", fov[0], er[0]);
    end
    tick();
    n_cmp++;
    if (er[0] !== 1'b0 || ec[0] !== 8'd1) begin
      n_bad++;
      $display("FAIL orphan_cnt: got e=%0b c=%0d want 0/1",
               er[0], ec[0]);
    end
    send(8'h83);
    n_cmp++;
    if (fov[2] !== 1'b0 || er[2] !== 1'b1 || fov[0] !== 1'b1) begin
      n_bad++;
      $display("FAIL bad_dest: got v2=%0b e2=%0b v0=%0b want 0/1/1",
               fov[2], er[2], fov[0]);
    end
    send(8'h00);
    n_cmp++;
    if (fov[2] !== 1'b0 || er[2] !== 1'b0) begin
      n_bad++;
      $display("FAIL drop_body: got v=%0b e=%0b want 0/0",
               fov[2], er[2]);
    end
    send(8'h40);
    n_cmp++;
    if (fov[2] !== 1'b0 || er[2] !== 1'b0) begin
      n_bad++;
      $display("FAIL drop_tail: got v=%0b e=%0b want 0/0",
               fov[2], er[2]);
    end
    send(8'hC1);
    n_cmp++;
    if (fov[2] !== 1'b1 || pn[2] !== 4'd1 || er[2] !== 1'b0) begin
      n_bad++;
      $display("FAIL drop_exit: got v=%0b p=%0d e=%0b want 1/1/0",
               fov[2], pn[2], er[2]);
    end
    n_cmp++;
    if (ec[2] !== 8'd2) begin
      n_bad++;
      $display("FAIL drop_cnt: got %0d want 2", ec[2]);
    end
    send(8'h83);
    send(8'h88);
    n_cmp++;
    if (er[0] !== 1'b1 || fov[0] !== 1'b1 || pn[0] !== 4'd4) begin
      n_bad++;
      $display("FAIL relock: got e=%0b v=%0b p=%0d want 1/1/4",
               er[0], fov[0], pn[0]);
    end
    send(8'h40);
    n_cmp++;
    if (er[0] !== 1'b0 || pn[0] !== 4'd4) begin
      n_bad++;
      $display("FAIL relock_tail: got e=%0b p=%0d want 0/4",
               er[0], pn[0]);
    end
  endtask

  task automatic test_saturate();
    do_reset();
    flit_in       = 8'h05;
    flit_in_valid = 1'b1;
    repeat (300) tick();
    flit_in_valid = 1'b0;
    tick();
    n_cmp++;
    if (ec[0] !== 8'd255 || er[0] !== 1'b0) begin
      n_bad++;
      $display("FAIL saturate: got c=%0d e=%0b want 255/0",
               ec[0], er[0]);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    flit_out_ready = 1'b0;
    flit_in        = 8'h83;
    flit_in_valid  = 1'b1;
    tick();
    flit_in = 8'h00;
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (fov[0] !== 1'b1 || fo[0] !== 8'h83 || pn[0] !== 4'd2 ||
          in_rdy[0] !== 1'b0) begin
        n_bad++;
        $display("FAIL bp_hold%0d: got v=%0b f=%h p=%0d r=%0b",
                 i, fov[0], fo[0], pn[0], in_rdy[0]);
      end
      tick();
    end
    flit_out_ready = 1'b1;
    #1;
    n_cmp++;
    if (in_rdy[0] !== 1'b1) begin
      n_bad++;
      $display("FAIL bp_release: got ready=%0b want 1", in_rdy[0]);
    end
    tick();
    flit_in_valid = 1'b0;
    n_cmp++;
    if (fov[0] !== 1'b1 || fo[0] !== 8'h00 || pn[0] !== 4'd2) begin
      n_bad++;
      $display("FAIL bp_refill: got v=%0b f=%h p=%0d want 1/00/2",
               fov[0], fo[0], pn[0]);
    end
    tick();
    n_cmp++;
    if (fov[0] !== 1'b0) begin
      n_bad++;
      $display("FAIL bp_drain: got v=%0b want 0", fov[0]);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    send(8'h83);
    rst = 1'b1;
    #1;
    n_cmp++;
    if (fov[0] !== 1'b0 || fo[0] !== 8'h00 || pn[0] !== 4'd0 ||
        pe[0] !== 5'd0) begin
      n_bad++;
      $display("FAIL mid_rst: got v=%0b f=%h p=%0d en=%b want zeros",
               fov[0], fo[0], pn[0], pe[0]);
    end
    tick();
    rst = 1'b0;
    tick();
    send(8'h00);
    n_cmp++;
    if (er[0] !== 1'b1 || ec[0] !== 8'd1 || fov[0] !== 1'b0) begin
      n_bad++;
      $display("FAIL mid_orphan: got e=%0b c=%0d v=%0b want 1/1/0",
               er[0], ec[0], fov[0]);
    end
  endtask

  task automatic test_random();
    bit drain;
    bit exp_rdy;
    do_reset();
    for (int d = 0; d < 3; d++) begin
      m_pkt[d]  = 1'b0;
      m_drop[d] = 1'b0;
      m_lock[d] = 0;
      m_full[d] = 1'b0;
      m_f[d]    = 8'h00;
      m_p[d]    = 0;
      m_err[d]  = 1'b0;
      m_cnt[d]  = 0;
    end
    for (int c = 0; c < 3000; c++) begin
      flit_in_valid  = ($urandom_range(0, 3) != 0);
      flit_in        = {2'($urandom), 2'($urandom),
                        2'($urandom), 2'($urandom)};
      flit_out_ready = ($urandom_range(0, 2) != 0);
      #1;
      for (int d = 0; d < 3; d++) begin
        exp_rdy = !m_full[d] || flit_out_ready;
        n_cmp++;
        if (in_rdy[d] !== exp_rdy || fov[d] !== m_full[d]) begin
          n_bad++;
          $display("FAIL rnd_hs%0d c%0d: got r=%0b v=%0b want %0b/%0b",
                   d, c, in_rdy[d], fov[d], exp_rdy, m_full[d]);
        end
        if (m_full[d]) begin
          n_cmp++;
          if (fo[d] !== m_f[d] || pn[d] !== 4'(m_p[d]) ||
              pe[d] !== en_of(m_p[d])) begin
            n_bad++;
            $display("FAIL rnd_out%0d c%0d: got %h/%0d/%b want %h/%0d",
                     d, c, fo[d], pn[d], pe[d], m_f[d], m_p[d]);
          end
        end
        drain    = m_full[d] && flit_out_ready;
        m_err[d] = 1'b0;
        if (drain) m_full[d] = 1'b0;
        if (flit_in_valid && exp_rdy) model_flit(d, flit_in);
      end
      tick();
      for (int d = 0; d < 3; d++) begin
        n_cmp++;
        if (er[d] !== m_err[d] || ec[d] !== 8'(m_cnt[d])) begin
          n_bad++;
          $display("FAIL rnd_err%0d c%0d: got %0b/%0d want %0b/%0d",
                   d, c, er[d], ec[d], m_err[d], m_cnt[d]);
        end
      end
    end
    flit_in_valid  = 1'b0;
    flit_out_ready = 1'b1;
  endtask

  initial begin
    rst            = 1'b1;
    flit_in        = 8'h00;
    flit_in_valid  = 1'b0;
    flit_out_ready = 1'b1;
    test_reset();
    test_wormhole();
    test_routing();
    test_local();
    test_errors();
    test_saturate();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
